sti_dac: RTL and testbench
==========================

Name: sti_dac

Overview:
- Serial transmitter plus data-arrangement controller.
- Each load captures a 16-bit parallel word, formats it to 8/16/24/32 bits, and shifts it out serially on so_data/so_valid.
- The same serial stream is packed into bytes and written sequentially into a 256-byte external pixel memory.
- After the last word (pi_end), remaining memory locations are zero-filled and pixel_finish is raised.

Parameters:
- None. Widths are fixed: data 16, pixel address 8, pixel data 8, memory depth 256.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset; one clock domain, reset is synchronous and active-high
- load  in  1  one-cycle strobe; capture pi_* inputs
- pi_data  in  16  parallel data word
- pi_length  in  2  00=8b, 01=16b, 10=24b, 11=32b
- pi_fill  in  1  24/32b: 1=data in MSBs, zeros in LSBs; 0=zeros in MSBs, data in LSBs
- pi_msb  in  1  1=MSB first, 0=LSB first
- pi_low  in  1  8b mode: 1=use pi_data[15:8], 0=use pi_data[7:0]
- pi_end  in  1  level; last word has been loaded
- so_data  out  1  serial data bit
- so_valid  out  1  so_data valid
- pixel_finish  out  1  all 256 bytes written (sticky)
- pixel_addr  out  8  pixel memory write address
- pixel_dataout  out  8  pixel memory write data
- pixel_wr  out  1  write strobe; memory captures on its rising edge

Behaviour:
- Reset: all outputs 0, internal write pointer 0, FSM to IDLE.
- Formatted word W, N bits:
  - 8b: W = pi_low ? pi_data[15:8] : pi_data[7:0]; N=8.
  - 16b: W = pi_data; N=16.
  - 24b: W = pi_fill ? {pi_data,8'h00} : {8'h00,pi_data}; N=24.
  - 32b: W = pi_fill ? {pi_data,16'h0000} : {16'h0000,pi_data}; N=32.
- FSM states: IDLE, LOAD, SHIFT, WAIT_WR, FILL, FINISH.
- IDLE: load sampled high at edge T latches W, N, pi_msb. load is ignored in any other state.
- SHIFT:
  - so_valid=1 for exactly N consecutive cycles, starting at edge T+1.
  - Bit k (k=0..N-1) is W[N-1-k] if msb-first, else W[k].
  - so_data is 0 whenever so_valid=0.
  - so_valid drops right after the last bit, and the block returns to IDLE ready for the next load.
- Byte packing:
  - Each group of 8 consecutive transmitted bits forms one pixel; the first received bit is bit 7 (MSB).
  - N is always a multiple of 8, so bytes never straddle words.
- Pixel write, per completed byte:
  - Cycle after the 8th bit: pixel_dataout <= byte, pixel_addr <= wptr, pixel_wr stays 0.
  - Next cycle: pixel_wr=1 for exactly one cycle.
  - Then pixel_wr=0 and wptr increments.
  - Address and data are stable for at least one cycle before and throughout the pixel_wr high phase.
  - Byte writes are at least 8 cycles apart, so they never overlap.
- End handling:
  - Once pi_end=1, the final transmission is over, and its last byte write has completed: if wptr ≠ 0 after wrap (fewer than 256 bytes written), enter FILL.
  - FILL: pixel_dataout=0, pixel_addr=wptr, pixel_wr pulsed 0→1 (2 cycles per byte), wptr incremented, until address 255 is written.
- FINISH:
  - pixel_finish=1 one cycle after the final pixel_wr falls; held until reset.
  - so_valid=0 and pixel_wr=0 in FINISH.
- If exactly 256 bytes came from data, go directly to FINISH.
- More than 256 bytes: wptr wraps modulo 256 (no error flag).
- reset asserted mid-shift or mid-fill aborts immediately to the reset state.

Decomposition:
- Package sti_dac_pkg holds:
  - length encodings LEN_8/16/24/32;
  - FSM state enum;
  - constants PIX_DEPTH=256, BYTE_W=8.
- One natural sub-module: sti_dac_packer.
  - Inputs: serial bit/valid.
  - Outputs: byte, byte_ready, and the write-strobe sequencing plus the zero-fill counter.
- The top holds the load/format/shift FSM.

Test Plan:
- 8b, pi_low=0, pi_msb=1, pi_data=16'hA55A → 8 valid cycles, so_data 0,1,0,1,1,0,1,0; pixel[0]=8'h5A.
- 8b, pi_low=1, pi_msb=0, pi_data=16'hA55A → so_data 1,0,1,0,0,1,0,1; next pixel=8'hA5.
- 24b, pi_fill=1, pi_msb=1, pi_data=16'h1234 → 24 bits of 24'h123400 MSB-first; pixels 12,34,00 at consecutive addresses.
- 32b, pi_fill=0, pi_msb=0, pi_data=16'h8001 → so_data 1 at bit indices 0 and 15, else 0; pixels 80,01,00,00.
- Issue 3 words, then pi_end → remaining addresses up to 255 written 00, pixel_finish rises after the last pixel_wr, all 256 locations match the expected image.
- Reset asserted during a 32b shift → so_valid/pixel_wr/pixel_finish=0 next edge; a fresh load then restarts at pixel_addr 0.

Source files
------------

// File: rtl/sti_dac_pkg.sv
// Shared widths, length encodings, FSM states and word formatting for sti_dac.
package sti_dac_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PIX_DEPTH = 256;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 6;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WAIT_WR,
    ST_FILL,
    ST_FINISH
  } state_t;

  // Formatted word, right-aligned in a 32-bit container.
  function automatic logic [WORD_W-1:0] format_word(input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        len,
                                                    input logic              fill,
                                                    input logic              low);
    logic [WORD_W-1:0] w;
    case (len)
      LEN_8:   w = low ? {24'h0, data[15:8]} : {24'h0, data[7:0]};
      LEN_16:  w = {16'h0, data};
      LEN_24:  w = fill ? {8'h0, data, 8'h00} : {16'h0, data};
      default: w = fill ? {data, 16'h0000} : {16'h0, data};
    endcase
    return w;
  endfunction

  // Number of serial bits for a length code: 8, 16, 24 or 32.
  function automatic logic [CNT_W-1:0] word_bits(input logic [1:0] len);
    return CNT_W'({len, 3'b000}) + CNT_W'(8);
  endfunction

endpackage

// File: rtl/sti_dac_packer.sv
// Packs the serial stream into bytes and sequences pixel memory writes,
// including the zero-fill of the remaining locations.
//   bit_in/bit_valid : serial stream from the shifter
//   fill_start       : one-cycle request to zero-fill from wptr up to the last address
//   pixel_*          : memory write port (address/data set one cycle before pixel_wr)
//   wptr             : next address to be written
//   busy_c           : a byte write or fill is still in flight
//   fill_done        : one-cycle pulse as the final fill write strobe falls
module sti_dac_packer
  import sti_dac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              fill_start,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [BYTE_W-1:0] pixel_dataout,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] wptr,
  output logic              busy_c,
  output logic              fill_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_DEPTH - 1);

  logic [BYTE_W-2:0] sr;
  logic [2:0]        bit_cnt;
  logic              byte_pending;
  logic              fill_active;

  assign busy_c = byte_pending | pixel_wr | fill_active;

  // Byte assembly, write strobe sequencing and fill address walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr            <= '0;
      bit_cnt       <= '0;
      byte_pending  <= 1'b0;
      fill_active   <= 1'b0;
      fill_done     <= 1'b0;
      pixel_addr    <= '0;
      pixel_dataout <= '0;
      pixel_wr      <= 1'b0;
      wptr          <= '0;
    end else begin
      fill_done <= 1'b0;

      // First received bit lands in the byte MSB.
      if (bit_valid) begin
        sr      <= {sr[BYTE_W-3:0], bit_in};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          pixel_dataout <= {sr, bit_in};
          pixel_addr    <= wptr;
          byte_pending  <= 1'b1;
        end
      end

      if (byte_pending) begin
        pixel_wr     <= 1'b1;
        byte_pending <= 1'b0;
      end

      if (pixel_wr) begin
        pixel_wr <= 1'b0;
        wptr     <= wptr + ADDR_W'(1);
        if (fill_active && wptr == LAST_ADDR) begin
          fill_active <= 1'b0;
          fill_done   <= 1'b1;
        end
      end

      // Fill: next zero byte is staged on the same edge the strobe falls.
      if (fill_start) begin
        fill_active   <= 1'b1;
        pixel_addr    <= wptr;
        pixel_dataout <= '0;
        byte_pending  <= 1'b1;
      end else if (fill_active && pixel_wr && wptr != LAST_ADDR) begin
        pixel_addr    <= wptr + ADDR_W'(1);
        pixel_dataout <= '0;
        byte_pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sti_dac.sv
// Serial transmitter and pixel memory arranger.
//   load/pi_*     : parallel word capture and formatting controls
//   pi_end        : level, no more words will follow
//   so_data/valid : serial output stream
//   pixel_*       : 256-byte pixel memory write port, pixel_finish when complete
module sti_dac
  import sti_dac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] pi_data,
  input  logic [1:0]        pi_length,
  input  logic              pi_fill,
  input  logic              pi_msb,
  input  logic              pi_low,
  input  logic              pi_end,
  output logic              so_data,
  output logic              so_valid,
  output logic              pixel_finish,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [BYTE_W-1:0] pixel_dataout,
  output logic              pixel_wr
);

  state_t            state;
  logic [WORD_W-1:0] sh;
  logic [CNT_W-1:0]  bits_left;
  logic              msb_first;
  logic              fill_start;

  logic [ADDR_W-1:0] wptr;
  logic              busy_c;
  logic              fill_done;

  logic [WORD_W-1:0] fw_c;
  logic [CNT_W-1:0]  n_c;

  assign fw_c = format_word(pi_data, pi_length, pi_fill, pi_low);
  assign n_c  = word_bits(pi_length);

  // Load/shift/end-handling controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sh           <= '0;
      bits_left    <= '0;
      msb_first    <= 1'b0;
      so_data      <= 1'b0;
      so_valid     <= 1'b0;
      fill_start   <= 1'b0;
      pixel_finish <= 1'b0;
    end else begin
      fill_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            // MSB-first words are left-aligned so both directions shift from a fixed end.
            sh        <= pi_msb ? (fw_c << (CNT_W'(WORD_W) - n_c)) : fw_c;
            bits_left <= n_c;
            msb_first <= pi_msb;
            state     <= ST_LOAD;
          end else if (pi_end) begin
            if (wptr == '0) begin
              state        <= ST_FINISH;
              pixel_finish <= 1'b1;
            end else begin
              state      <= ST_FILL;
              fill_start <= 1'b1;
            end
          end
        end
        ST_LOAD, ST_SHIFT: begin
          if (bits_left == '0) begin
            so_valid <= 1'b0;
            so_data  <= 1'b0;
            state    <= ST_WAIT_WR;
          end else begin
            so_valid  <= 1'b1;
            so_data   <= msb_first ? sh[WORD_W-1] : sh[0];
            sh        <= msb_first ? (sh << 1) : (sh >> 1);
            bits_left <= bits_left - CNT_W'(1);
            state     <= ST_SHIFT;
          end
        end
        ST_WAIT_WR: begin
          if (!busy_c) state <= ST_IDLE;
        end
        ST_FILL: begin
          if (fill_done) begin
            state        <= ST_FINISH;
            pixel_finish <= 1'b1;
          end
        end
        ST_FINISH: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sti_dac_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .bit_in        (so_data),
    .bit_valid     (so_valid),
    .fill_start    (fill_start),
    .pixel_addr    (pixel_addr),
    .pixel_dataout (pixel_dataout),
    .pixel_wr      (pixel_wr),
    .wptr          (wptr),
    .busy_c        (busy_c),
    .fill_done     (fill_done)
  );

endmodule

// File: tb/tb_sti_dac.sv
module tb_sti_dac;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic        so_data, so_valid, pixel_finish, pixel_wr;
  logic [7:0]  pixel_addr, pixel_dataout;

  always #5 clk = ~clk;

  sti_dac dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_data(so_data), .so_valid(so_valid), .pixel_finish(pixel_finish),
    .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout), .pixel_wr(pixel_wr)
  );

  int total = 0;
  int bad   = 0;

  // Reference image and write pointer kept by the bench.
  logic [7:0] exp_mem [256];
  int         exp_wptr;
  logic [7:0] acc;

  // What the memory actually received.
  logic [7:0] dut_mem [256];
  int         wr_log [$];

  always @(posedge pixel_wr) begin
    dut_mem[pixel_addr] = pixel_dataout;
    wr_log.push_back(int'(pixel_addr));
  end

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [31:0] stream;  // expected bits, first transmitted bit at [31]
    int          nbits;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'h00;
      dut_mem[i] = 8'hxx;
    end
    exp_wptr = 0;
    acc      = 8'h00;
    wr_log.delete();
  endtask

  // Spec-level model of the serial stream for one word.
  task automatic model_stream(input logic [15:0] d, input logic [1:0] len, input logic fill,
                              input logic msb, input logic low,
                              output logic [31:0] s, output int n);
    longint w;
    n = 8 * (int'(len) + 1);
    case (len)
      2'd0:    w = low ? longint'(d) / 256 : longint'(d) % 256;
      2'd1:    w = longint'(d);
      2'd2:    w = fill ? longint'(d) * 256 : longint'(d);
      default: w = fill ? longint'(d) * 65536 : longint'(d);
    endcase
    s = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (msb) s[31-k] = 1'((w >> (n - 1 - k)) & 1);
      else     s[31-k] = 1'((w >> k) & 1);
    end
  endtask

  task automatic apply_word(input logic [15:0] d, input logic [1:0] len, input logic fill,
                            input logic msb, input logic low,
                            input logic [31:0] s, input int n);
    @(posedge clk); #1;
    load = 1'b1; pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
    @(posedge clk); #1;
    load = 1'b0;
    @(negedge clk);
    chk("valid_latency", {31'b0, so_valid}, 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("valid_bit%0d", k), {31'b0, so_valid}, 32'd1);
      chk($sformatf("data_bit%0d", k), {31'b0, so_data}, {31'b0, s[31-k]});
      acc = {acc[6:0], s[31-k]};
      if (k % 8 == 7) begin
        exp_mem[exp_wptr % 256] = acc;
        exp_wptr++;
      end
    end
    @(negedge clk);
    chk("valid_drop", {31'b0, so_valid}, 32'd0);
    chk("data_idle", {31'b0, so_data}, 32'd0);
    repeat (8) @(posedge clk);
  endtask

  task automatic random_word(input logic [1:0] len);
    logic [15:0] d;
    logic        f, m, l;
    logic [31:0] s;
    int          n;
    d = 16'($urandom); f = 1'($urandom); m = 1'($urandom); l = 1'($urandom);
    model_stream(d, len, f, m, l, s, n);
    apply_word(d, len, f, m, l, s, n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; load = 1'b0; pi_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic wait_finish();
    int c;
    c = 0;
    while (!pixel_finish && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("finish_seen", {31'b0, pixel_finish}, 32'd1);
  endtask

  task automatic check_image();
    chk("write_count", 32'(wr_log.size()), 32'd256);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("pix%0d", i), {24'b0, dut_mem[i]}, {24'b0, exp_mem[i]});
      if (i < wr_log.size()) chk($sformatf("addr_order%0d", i), 32'(wr_log[i]), 32'(i));
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    model_clear();

    vecs[0] = '{16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0, 32'h5A00_0000, 8};
    vecs[1] = '{16'hA55A, 2'd0, 1'b0, 1'b0, 1'b1, 32'hA500_0000, 8};
    vecs[2] = '{16'h1234, 2'd2, 1'b1, 1'b1, 1'b0, 32'h1234_0000, 24};
    vecs[3] = '{16'h8001, 2'd3, 1'b0, 1'b0, 1'b0, 32'h8001_0000, 32};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_so_valid", {31'b0, so_valid}, 32'd0);
    chk("rst_so_data", {31'b0, so_data}, 32'd0);
    chk("rst_pixel_wr", {31'b0, pixel_wr}, 32'd0);
    chk("rst_finish", {31'b0, pixel_finish}, 32'd0);
    chk("rst_addr", {24'b0, pixel_addr}, 32'd0);
    chk("rst_dataout", {24'b0, pixel_dataout}, 32'd0);
    #1 reset = 1'b0;

    // Phase A: directed table, random words, then end with zero-fill.
    for (int i = 0; i < 4; i++)
      apply_word(vecs[i].data, vecs[i].len, vecs[i].fill, vecs[i].msb, vecs[i].low,
                 vecs[i].stream, vecs[i].nbits);
    chk("tbl_pix0", {24'b0, dut_mem[0]}, 32'h5A);
    chk("tbl_pix1", {24'b0, dut_mem[1]}, 32'hA5);
    chk("tbl_pix2", {24'b0, dut_mem[2]}, 32'h12);
    chk("tbl_pix3", {24'b0, dut_mem[3]}, 32'h34);
    chk("tbl_pix5", {24'b0, dut_mem[5]}, 32'h80);
    chk("tbl_pix6", {24'b0, dut_mem[6]}, 32'h01);
    for (int i = 0; i < 20; i++) random_word(2'($urandom_range(0, 3)));
    @(posedge clk); #1 pi_end = 1'b1;
    wait_finish();
    @(negedge clk);
    chk("finish_held", {31'b0, pixel_finish}, 32'd1);
    chk("finish_wr_low", {31'b0, pixel_wr}, 32'd0);
    chk("finish_valid_low", {31'b0, so_valid}, 32'd0);
    check_image();

    // Phase B: exactly 256 data bytes, no fill expected.
    do_reset();
    chk("rstB_finish", {31'b0, pixel_finish}, 32'd0);
    for (int i = 0; i < 64; i++) random_word(2'd3);
    @(posedge clk); #1 pi_end = 1'b1;
    wait_finish();
    repeat (4) @(negedge clk);
    check_image();

    // Phase C: reset in the middle of a 32-bit shift, then restart from address 0.
    do_reset();
    @(posedge clk); #1;
    load = 1'b1; pi_data = 16'hBEEF; pi_length = 2'd3; pi_fill = 1'b1; pi_msb = 1'b1; pi_low = 1'b0;
    @(posedge clk); #1 load = 1'b0;
    repeat (14) @(negedge clk);
    chk("midshift_valid", {31'b0, so_valid}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", {31'b0, so_valid}, 32'd0);
    chk("abort_wr", {31'b0, pixel_wr}, 32'd0);
    chk("abort_finish", {31'b0, pixel_finish}, 32'd0);
    reset = 1'b0;
    model_clear();
    apply_word(vecs[0].data, vecs[0].len, vecs[0].fill, vecs[0].msb, vecs[0].low,
               vecs[0].stream, vecs[0].nbits);
    chk("restart_writes", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() > 0) chk("restart_addr", 32'(wr_log[0]), 32'd0);
    chk("restart_pix", {24'b0, dut_mem[0]}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
